// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - geometry, types and FSM encoding shared by the data cache
package data_cache_pkg;
  localparam int WORD_SIZE   = 16;
  localparam int LINE_WORDS  = 4;
  localparam int NUM_LINES   = 4;
  localparam int OFFSET_BITS = 2;
  localparam int INDEX_BITS  = 2;
  localparam int TAG_BITS    = 12;

  typedef logic [WORD_SIZE-1:0]            word_t;
  typedef logic [WORD_SIZE*LINE_WORDS-1:0] line_t;
  typedef logic [TAG_BITS-1:0]             tag_t;
  typedef logic [INDEX_BITS-1:0]           index_t;
  typedef logic [OFFSET_BITS-1:0]          offset_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  function automatic word_t line_base(input word_t addr);
    return {addr[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - backing-memory req/ack bus between the cache and memory
interface data_cache_if;
  import data_cache_pkg::*;

  logic  mem_req;
  logic  mem_we;
  word_t mem_addr;
  word_t mem_wdata;
  line_t mem_rdata;
  logic  mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/data_cache_array.sv
// rtl/data_cache_array.sv - tag/valid/data storage: combinational read, line fill, word write
module data_cache_array
  import data_cache_pkg::*;
(
  input  logic    clk,
  input  logic    Reset_N,
  input  index_t  rd_index_i,
  input  offset_t rd_offset_i,
  output tag_t    rd_tag_o,
  output logic    rd_valid_o,
  output word_t   rd_word_o,
  input  logic    fill_en_i,
  input  index_t  fill_index_i,
  input  tag_t    fill_tag_i,
  input  line_t   fill_line_i,
  input  logic    wr_en_i,
  input  index_t  wr_index_i,
  input  offset_t wr_offset_i,
  input  word_t   wr_word_i
);
  logic [NUM_LINES-1:0] valid_q;
  tag_t                 tag_q  [NUM_LINES];
  word_t                data_q [NUM_LINES][LINE_WORDS];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_word_o  = data_q[rd_index_i][rd_offset_i];

  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_index_i] <= 1'b1;
    end
  end

  // Tags and data need no reset: nothing reads them while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_index_i] <= fill_tag_i;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_q[fill_index_i][w] <= fill_line_i[w*WORD_SIZE +: WORD_SIZE];
      end
    end else if (wr_en_i) begin
      data_q[wr_index_i][wr_offset_i] <= wr_word_i;
    end
  end
endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through, no-write-allocate data cache for the MEM stage
module data_cache
  import data_cache_pkg::*;
(
  input  logic         clk,
  input  logic         Reset_N,
  input  logic         MemReadMEM,
  input  logic         MemWriteMEM,
  input  word_t        ALUresultMEM,
  input  word_t        forwardBMEM,
  input  logic         pipeAdvance,
  output word_t        realData,
  output logic         cacheHit2,
  output logic         writeToData,
  data_cache_if.master mem_bus,
  output word_t        hit_count,
  output word_t        miss_count
);
  state_e state_q;
  logic   wr_done_q;
  word_t  hit_cnt_q, miss_cnt_q;
  logic   req_q, we_q;
  word_t  addr_q, wdata_q;

  tag_t   rd_tag;
  logic   rd_valid;
  word_t  rd_word;
  logic   hit;
  logic   store;
  logic   fill_en, wr_en;

  assign hit     = rd_valid && (rd_tag == ALUresultMEM[WORD_SIZE-1:OFFSET_BITS+INDEX_BITS]);
  assign store   = MemWriteMEM && !MemReadMEM;
  assign fill_en = (state_q == ST_FILL) && mem_bus.mem_ack;
  assign wr_en   = (state_q == ST_WRITE) && mem_bus.mem_ack && hit;

  data_cache_array u_array (
    .clk          (clk),
    .Reset_N      (Reset_N),
    .rd_index_i   (ALUresultMEM[OFFSET_BITS +: INDEX_BITS]),
    .rd_offset_i  (ALUresultMEM[OFFSET_BITS-1:0]),
    .rd_tag_o     (rd_tag),
    .rd_valid_o   (rd_valid),
    .rd_word_o    (rd_word),
    .fill_en_i    (fill_en),
    .fill_index_i (ALUresultMEM[OFFSET_BITS +: INDEX_BITS]),
    .fill_tag_i   (ALUresultMEM[WORD_SIZE-1:OFFSET_BITS+INDEX_BITS]),
    .fill_line_i  (mem_bus.mem_rdata),
    .wr_en_i      (wr_en),
    .wr_index_i   (ALUresultMEM[OFFSET_BITS +: INDEX_BITS]),
    .wr_offset_i  (ALUresultMEM[OFFSET_BITS-1:0]),
    .wr_word_i    (forwardBMEM)
  );

  assign realData    = (MemReadMEM && hit) ? rd_word : '0;
  assign cacheHit2   = !((state_q == ST_FILL) ||
                         ((state_q == ST_IDLE) && MemReadMEM && !hit));
  assign writeToData = (state_q == ST_WRITE) ||
                       ((state_q == ST_IDLE) && store && !wr_done_q);

  assign mem_bus.mem_req   = req_q;
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;
  assign hit_count         = hit_cnt_q;
  assign miss_count        = miss_cnt_q;

  // wr_done lets the completed store advance the pipeline exactly once before the next WRITE.
  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q    <= ST_IDLE;
      wr_done_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MemReadMEM) begin
            if (hit) begin
              if (pipeAdvance) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
              state_q    <= ST_FILL;
              miss_cnt_q <= miss_cnt_q + 16'd1;
              req_q      <= 1'b1;
              we_q       <= 1'b0;
              addr_q     <= line_base(ALUresultMEM);
            end
          end else if (MemWriteMEM) begin
            if (wr_done_q) begin
              wr_done_q <= 1'b0;
            end else begin
              state_q <= ST_WRITE;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= ALUresultMEM;
              wdata_q <= forwardBMEM;
            end
          end
        end
        ST_FILL: begin
          if (mem_bus.mem_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (mem_bus.mem_ack) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            wr_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache
module tb_data_cache;
  import data_cache_pkg::*;

  logic  clk;
  logic  Reset_N;
  logic  MemReadMEM, MemWriteMEM;
  word_t ALUresultMEM, forwardBMEM;
  logic  pipeAdvance;
  word_t realData;
  logic  cacheHit2, writeToData;
  word_t hit_count, miss_count;

  data_cache_if bus ();

  data_cache dut (
    .clk          (clk),
    .Reset_N      (Reset_N),
    .MemReadMEM   (MemReadMEM),
    .MemWriteMEM  (MemWriteMEM),
    .ALUresultMEM (ALUresultMEM),
    .forwardBMEM  (forwardBMEM),
    .pipeAdvance  (pipeAdvance),
    .realData     (realData),
    .cacheHit2    (cacheHit2),
    .writeToData  (writeToData),
    .mem_bus      (bus),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  int passed = 0;
  int total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pipeAdvance = cacheHit2 && !writeToData;

  // Backing memory: responds lat cycles after mem_req rises, on the falling edge.
  word_t bmem [0:511];
  int    lat;
  int    cnt;
  bit    model_en;
  logic  model_ack, man_ack;
  line_t model_rdata;

  assign bus.mem_ack   = model_ack | man_ack;
  assign bus.mem_rdata = man_ack ? 64'hDEAD_DEAD_DEAD_DEAD : model_rdata;

  always @(negedge clk) begin
    model_ack = 1'b0;
    if (!Reset_N) begin
      cnt = 0;
      model_rdata = '0;
      for (int i = 0; i < 512; i++) bmem[i] = 16'(i) ^ 16'h5A00;
      bmem[16'h10] = 16'h1111;
      bmem[16'h11] = 16'h2222;
      bmem[16'h12] = 16'h3333;
      bmem[16'h13] = 16'h4444;
    end else if (model_en && bus.mem_req) begin
      cnt++;
      if (cnt >= lat) begin
        cnt = 0;
        model_ack = 1'b1;
        if (bus.mem_we) begin
          bmem[bus.mem_addr[8:0]] = bus.mem_wdata;
        end else begin
          model_rdata = {bmem[bus.mem_addr[8:0] + 9'd3], bmem[bus.mem_addr[8:0] + 9'd2],
                         bmem[bus.mem_addr[8:0] + 9'd1], bmem[bus.mem_addr[8:0]]};
        end
      end
    end else begin
      cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (Reset_N) begin
      assert (!(MemReadMEM && MemWriteMEM))
      else begin
        total++;
        $error("FAIL illegal_req observed=both expected=exclusive");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 with the load removed.
  task automatic do_load(input string tag, input word_t a, input int l, input int exp_low,
                         input word_t exp_d, input word_t exp_hc, input word_t exp_mc);
    int    lowc;
    word_t sa;
    lat = l;
    MemReadMEM = 1'b1;
    ALUresultMEM = a;
    #1;
    lowc = 0;
    sa = '0;
    while (!cacheHit2 && lowc < 50) begin
      if (bus.mem_req) sa = bus.mem_addr;
      lowc++;
      @(posedge clk);
      #2;
    end
    chk({tag, "_stall"}, 32'(lowc), 32'(exp_low));
    chk({tag, "_data"}, 32'(realData), 32'(exp_d));
    chk({tag, "_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_hits"}, 32'(hit_count), 32'(exp_hc));
    chk({tag, "_misses"}, 32'(miss_count), 32'(exp_mc));
    if (exp_low > 0) chk({tag, "_addr"}, 32'(sa), 32'({a[15:2], 2'b00}));
    @(posedge clk);
    #1;
    MemReadMEM = 1'b0;
  endtask

  task automatic do_store(input string tag, input word_t a, input word_t d, input int l,
                          input int exp_w);
    int    wc;
    word_t sa, sd;
    logic  swe;
    lat = l;
    MemWriteMEM = 1'b1;
    ALUresultMEM = a;
    forwardBMEM = d;
    #1;
    wc = 0;
    sa = '0;
    sd = '0;
    swe = 1'b0;
    while (writeToData && wc < 50) begin
      if (bus.mem_req) begin
        sa = bus.mem_addr;
        sd = bus.mem_wdata;
        swe = bus.mem_we;
      end
      wc++;
      @(posedge clk);
      #2;
    end
    chk({tag, "_stall"}, 32'(wc), 32'(exp_w));
    chk({tag, "_addr"}, 32'(sa), 32'(a));
    chk({tag, "_wdata"}, 32'(sd), 32'(d));
    chk({tag, "_we"}, 32'(swe), 32'd1);
    chk({tag, "_mem"}, 32'(bmem[a[8:0]]), 32'(d));
    @(posedge clk);
    #1;
    MemWriteMEM = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_N = 1'b0;
    MemReadMEM = 1'b0;
    MemWriteMEM = 1'b0;
    ALUresultMEM = '0;
    forwardBMEM = '0;
    man_ack = 1'b0;
    model_en = 1'b1;
    lat = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_realData", 32'(realData), 32'd0);
    chk("rst_cacheHit2", 32'(cacheHit2), 32'd1);
    chk("rst_writeToData", 32'(writeToData), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_misses", 32'(miss_count), 32'd0);
    @(posedge clk);
    #1;
    Reset_N = 1'b1;
    @(posedge clk);
    #1;

    do_load("cold", 16'h0012, 3, 4, 16'h3333, 16'd0, 16'd1);
    do_load("next", 16'h0013, 3, 0, 16'h4444, 16'd1, 16'd1);
    do_store("st_hit", 16'h0011, 16'hBEEF, 2, 3);
    do_load("ld_st", 16'h0011, 1, 0, 16'hBEEF, 16'd2, 16'd1);
    do_store("st_miss", 16'h0100, 16'h1234, 2, 3);
    do_load("ld_noalloc", 16'h0100, 2, 3, 16'h1234, 16'd3, 16'd2);
    do_load("conf_a", 16'h0012, 1, 2, 16'h3333, 16'd4, 16'd3);
    do_load("conf_b", 16'h0112, 1, 2, 16'h5B12, 16'd5, 16'd4);
    do_load("conf_c", 16'h0012, 1, 2, 16'h3333, 16'd6, 16'd5);
    #1;
    chk("hits_total", 32'(hit_count), 32'd7);
    do_store("b2b_0", 16'h0200, 16'h0A0A, 1, 2);
    do_store("b2b_1", 16'h0201, 16'h0B0B, 1, 2);

    model_en = 1'b0;
    MemReadMEM = 1'b1;
    ALUresultMEM = 16'h0030;
    @(posedge clk);
    #2;
    chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
    Reset_N = 1'b0;
    MemReadMEM = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.mem_req), 32'd0);
    chk("async_rst_misses", 32'(miss_count), 32'd0);
    @(posedge clk);
    #1;
    Reset_N = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    #1;
    chk("stale_ack_req", 32'(bus.mem_req), 32'd0);
    chk("stale_ack_hit2", 32'(cacheHit2), 32'd1);
    chk("stale_ack_wtd", 32'(writeToData), 32'd0);
    chk("stale_ack_hits", 32'(hit_count), 32'd0);
    chk("stale_ack_misses", 32'(miss_count), 32'd0);
    model_en = 1'b1;
    @(posedge clk);
    #1;
    do_load("rst_reload", 16'h0012, 1, 2, 16'h3333, 16'd0, 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
